// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the functional-unit result handshake and the
// Common Data Bus broadcast.
// The master modport is the functional-unit / consumer side.
// The slave modport is the arbiter side.
interface cdb_arbiter_if #(
  parameter int FU_NUM = 3,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  localparam int SRC_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  // Functional-unit results, one slice per FU
  logic [FU_NUM-1:0]        fu_valid;
  logic [FU_NUM*TAG_W-1:0]  fu_tag;
  logic [FU_NUM*DATA_W-1:0] fu_value;
  logic [FU_NUM-1:0]        fu_ready;

  // Registered CDB broadcast
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_value;
  logic [SRC_W-1:0]         cdb_src;

  modport master (
    output fu_valid,
    output fu_tag,
    output fu_value,
    input  fu_ready,
    input  cdb_valid,
    input  cdb_tag,
    input  cdb_value,
    input  cdb_src
  );

  modport slave (
    input  fu_valid,
    input  fu_tag,
    input  fu_value,
    output fu_ready,
    output cdb_valid,
    output cdb_tag,
    output cdb_value,
    output cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered Common Data Bus among FU_NUM functional
// units.
// Each FU owns a one-entry holding buffer. A round-robin arbiter picks one
// buffered result per cycle and broadcasts it on the next edge. squash flushes
// every buffer and the CDB register without moving the round-robin pointer.
//
// Optional feature macro: CDB_BYPASS_EN
//   When defined, an FU with an empty buffer may request directly with its
//   incoming result. If it wins, the result goes straight to the CDB register,
//   giving 1-edge latency.
//   When undefined, only buffered results request, giving a fixed 2-edge latency.
module cdb_arbiter #(
  parameter int FU_NUM = 3,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(FU_NUM - 1);
  localparam logic [SRC_W:0]   FU_NUM_W = (SRC_W + 1)'(FU_NUM);

  // Holding buffers
  logic [FU_NUM-1:0] full_r;
  logic [TAG_W-1:0]  tag_r   [FU_NUM];
  logic [DATA_W-1:0] value_r [FU_NUM];

  // Arbitration state and CDB register
  logic [SRC_W-1:0]  rr_ptr_r;
  logic              cdb_valid_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [DATA_W-1:0] cdb_value_r;
  logic [SRC_W-1:0]  cdb_src_r;

  // Combinational arbitration signals
  logic [FU_NUM-1:0] req_s;
  logic [FU_NUM-1:0] grant_s;
  logic [FU_NUM-1:0] ready_s;
  logic [FU_NUM-1:0] accept_s;
  logic [FU_NUM-1:0] bypass_s;
  logic              grant_any_s;
  logic [SRC_W-1:0]  winner_s;
  logic              found_s;
  logic              hit_s;
  logic [SRC_W:0]    sum_s;
  logic [SRC_W:0]    wrap_s;
  logic [SRC_W-1:0]  idx_s;
  logic [TAG_W-1:0]  win_tag_s;
  logic [DATA_W-1:0] win_value_s;
  logic [SRC_W-1:0]  rr_next_s;

  // Request vector: buffered results, plus direct requests when bypass is built in
  always_comb begin
`ifdef CDB_BYPASS_EN
    req_s = full_r | bus.fu_valid;
`else
    req_s = full_r;
`endif
  end

  // Round-robin search starting at rr_ptr_r; the first requester found wins
  always_comb begin
    grant_s  = {FU_NUM{1'b0}};
    winner_s = {SRC_W{1'b0}};
    found_s  = 1'b0;
    hit_s    = 1'b0;
    sum_s    = {(SRC_W+1){1'b0}};
    wrap_s   = {(SRC_W+1){1'b0}};
    idx_s    = {SRC_W{1'b0}};
    for (int k = 0; k < FU_NUM; k++) begin
      sum_s          = {1'b0, rr_ptr_r} + (SRC_W + 1)'(k);
      wrap_s         = sum_s - FU_NUM_W;
      idx_s          = (sum_s >= FU_NUM_W) ? wrap_s[SRC_W-1:0] : sum_s[SRC_W-1:0];
      hit_s          = ~found_s & req_s[idx_s];
      grant_s[idx_s] = hit_s;
      winner_s       = hit_s ? idx_s : winner_s;
      found_s        = found_s | hit_s;
    end
  end

  assign grant_any_s = |grant_s;

  // Ready/accept: a buffer takes a new result when empty or being drained, never during squash or reset
  always_comb begin
    ready_s  = {FU_NUM{~reset & ~squash}} & (~full_r | grant_s);
    accept_s = bus.fu_valid & ready_s;
  end

  // Bypass marks a winner whose buffer is empty: its incoming result skips the buffer
  always_comb begin
`ifdef CDB_BYPASS_EN
    bypass_s = grant_s & ~full_r;
`else
    bypass_s = {FU_NUM{1'b0}};
`endif
  end

  // Winner data: buffered entry, or the live FU input when the winner is bypassing
  always_comb begin
    win_tag_s   = tag_r[winner_s];
    win_value_s = value_r[winner_s];
`ifdef CDB_BYPASS_EN
    if (!full_r[winner_s]) begin
      win_tag_s   = bus.fu_tag[winner_s*TAG_W +: TAG_W];
      win_value_s = bus.fu_value[winner_s*DATA_W +: DATA_W];
    end else begin
      win_tag_s   = tag_r[winner_s];
      win_value_s = value_r[winner_s];
    end
`endif
  end

  // Pointer advance: one past the winner, wrapping from the last FU to 0
  always_comb begin
    if (winner_s == LAST_IDX) begin
      rr_next_s = {SRC_W{1'b0}};
    end else begin
      rr_next_s = winner_s + SRC_W'(1);
    end
  end

  // Holding buffers: load on accept (reload when also granted), drain on grant, flush on squash
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_r <= {FU_NUM{1'b0}};
      for (int i = 0; i < FU_NUM; i++) begin
        tag_r[i]   <= {TAG_W{1'b0}};
        value_r[i] <= {DATA_W{1'b0}};
      end
    end else if (squash) begin
      full_r <= {FU_NUM{1'b0}};
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (accept_s[i] && !bypass_s[i]) begin
          full_r[i]  <= 1'b1;
          tag_r[i]   <= bus.fu_tag[i*TAG_W +: TAG_W];
          value_r[i] <= bus.fu_value[i*DATA_W +: DATA_W];
        end else if (grant_s[i]) begin
          full_r[i]  <= 1'b0;
        end else begin
          full_r[i]  <= full_r[i];
        end
      end
    end
  end

  // CDB register and round-robin pointer; payload holds when there is no grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= {TAG_W{1'b0}};
      cdb_value_r <= {DATA_W{1'b0}};
      cdb_src_r   <= {SRC_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
    end else if (squash) begin
      cdb_valid_r <= 1'b0;
    end else begin
      cdb_valid_r <= grant_any_s;
      if (grant_any_s) begin
        cdb_tag_r   <= win_tag_s;
        cdb_value_r <= win_value_s;
        cdb_src_r   <= winner_s;
        rr_ptr_r    <= rr_next_s;
      end
    end
  end

  assign bus.fu_ready  = ready_s;
  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_tag   = cdb_tag_r;
  assign bus.cdb_value = cdb_value_r;
  assign bus.cdb_src   = cdb_src_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scenario tasks plus randomized traffic for cdb_arbiter.
// A reference model of buffers, pointer and CDB tracks the expected state.
// Honours CDB_BYPASS_EN the same way the design does.
module tb_cdb_arbiter;
  localparam int FU_NUM = 3;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic squash;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.FU_NUM(FU_NUM), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();
  cdb_arbiter #(.FU_NUM(FU_NUM), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .squash(squash), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [2:0]  m_full;
  logic [4:0]  m_tag [3];
  logic [31:0] m_val [3];
  int          m_rr;
  logic        m_cv;
  logic [4:0]  m_ct;
  logic [31:0] m_cval;
  logic [1:0]  m_cs;

  task automatic model_reset();
    m_full = 3'b000; m_rr = 0; m_cv = 1'b0; m_ct = 5'd0; m_cval = 32'd0; m_cs = 2'd0;
    for (int i = 0; i < 3; i++) begin m_tag[i] = 5'd0; m_val[i] = 32'd0; end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < FU_NUM; k++) begin
      int i;
      i = (m_rr + k) % FU_NUM;
      if (m_full[i] || (BYP && bus.fu_valid[i])) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    int w;
    w = m_winner();
    for (int i = 0; i < 3; i++) r[i] = !reset && !squash && (!m_full[i] || w == i);
    return r;
  endfunction

  function automatic logic [42:0] m_out();
    return {m_ready(), m_cv, m_ct, m_cval, m_cs};
  endfunction

  function automatic logic [42:0] obs();
    return {bus.fu_ready, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, bus.cdb_src};
  endfunction

  task automatic set_fu(input int i, input logic v, input logic [4:0] t, input logic [31:0] d);
    bus.fu_valid[i] = v;
    bus.fu_tag[i*TAG_W +: TAG_W] = t;
    bus.fu_value[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle();
    bus.fu_valid = 3'b000;
    squash = 1'b0;
  endtask

  // Advance the model by one edge from the current inputs, then cross the edge
  task automatic tick();
    int w;
    logic [2:0] r;
    w = m_winner();
    r = m_ready();
    if (squash) begin
      m_full = 3'b000;
      m_cv = 1'b0;
    end else begin
      if (w >= 0) begin
        m_cv = 1'b1;
        m_cs = 2'(w);
        if (m_full[w]) begin
          m_ct = m_tag[w]; m_cval = m_val[w];
        end else begin
          m_ct = bus.fu_tag[w*TAG_W +: TAG_W]; m_cval = bus.fu_value[w*DATA_W +: DATA_W];
        end
        m_rr = (w + 1) % FU_NUM;
      end else begin
        m_cv = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (r[i] && bus.fu_valid[i]) begin
          if (!(BYP && w == i && !m_full[i])) begin
            m_full[i] = 1'b1;
            m_tag[i] = bus.fu_tag[i*TAG_W +: TAG_W];
            m_val[i] = bus.fu_value[i*DATA_W +: DATA_W];
          end
        end else if (w == i) begin
          m_full[i] = 1'b0;
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clock);
    vectors++;
    if (obs() !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", obs());
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.fu_ready !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 111", bus.fu_ready);
    end
    tick();
  endtask

  task automatic test_single();
    int lat;
    lat = BYP ? 1 : 2;
    set_fu(1, 1'b1, 5'd5, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL single_model c%0d: got %h want %h", c, obs(), m_out());
      end
      vectors++;
      if (bus.cdb_valid !== (c == lat)) begin
        miscompares++;
        $display("FAIL single_valid c%0d: got %b want %b", c, bus.cdb_valid, (c == lat));
      end
      if (c == lat) begin
        vectors++;
        if ({bus.cdb_tag, bus.cdb_value, bus.cdb_src} !== {5'd5, 32'hDEADBEEF, 2'd1}) begin
          miscompares++;
          $display("FAIL single_payload: got %h/%h/%0d want 5/deadbeef/1",
                   bus.cdb_tag, bus.cdb_value, bus.cdb_src);
        end
      end
      tick();
      bus.fu_valid[1] = 1'b0;
    end
  endtask

  task automatic test_all_valid();
    int cnt [3];
    int rc [3];
    logic [31:0] vals [3];
    logic [2:0] acc;
    int bcast;
    do_reset();
    bcast = 0;
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; rc[i] = 0; vals[i] = $urandom; end
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) set_fu(i, 1'b1, 5'(i*8 + cnt[i]), vals[i]);
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL all_model c%0d: got %h want %h", c, obs(), m_out());
      end
      if (c >= 3 && c <= 8) for (int i = 0; i < 3; i++) rc[i] += int'(bus.fu_ready[i]);
      if (bus.cdb_valid) begin
        vectors++;
        if ({bus.cdb_src, bus.cdb_tag} !== {2'(bcast % 3), 5'((bcast % 3)*8 + bcast/3)}) begin
          miscompares++;
          $display("FAIL all_order b%0d: got src %0d tag %0d want src %0d tag %0d",
                   bcast, bus.cdb_src, bus.cdb_tag, bcast % 3, (bcast % 3)*8 + bcast/3);
        end
        bcast++;
      end
      acc = bus.fu_ready;
      tick();
      for (int i = 0; i < 3; i++) if (acc[i]) begin cnt[i]++; vals[i] = $urandom; end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rc[i] != 2) begin
        miscompares++;
        $display("FAIL all_fairness fu%0d: got %0d ready cycles want 2", i, rc[i]);
      end
    end
    vectors++;
    if (bcast < 9) begin
      miscompares++;
      $display("FAIL all_throughput: got %0d broadcasts want >= 9", bcast);
    end
    idle();
  endtask

  task automatic test_backpressure();
    int t0, nb, blocked;
    int bs [5];
    int bt [5];
    int bc [5];
    int exp_s [5];
    int exp_t [5];
    logic acc0;
    exp_s = '{1, 2, 0, 0, 0};
    exp_t = '{1, 20, 10, 11, 12};
    do_reset();
    t0 = 10; nb = 0; blocked = 0;
    for (int c = 0; c < 10; c++) begin
      set_fu(1, c == 0, 5'd1, 32'h11);
      set_fu(2, c == 2, 5'd20, 32'h22);
      set_fu(0, c >= 2 && c <= 7, 5'(t0), 32'(t0) + 32'h100);
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL bp_model c%0d: got %h want %h", c, obs(), m_out());
      end
      if (bus.fu_valid[0] && !bus.fu_ready[0]) blocked++;
      if (bus.cdb_valid && nb < 5) begin
        bs[nb] = int'(bus.cdb_src); bt[nb] = int'(bus.cdb_tag); bc[nb] = c; nb++;
      end
      acc0 = bus.fu_valid[0] & bus.fu_ready[0];
      tick();
      if (acc0) t0++;
    end
    vectors++;
    if (nb != 5) begin
      miscompares++;
      $display("FAIL bp_count: got %0d broadcasts want 5", nb);
    end
    for (int k = 0; k < nb; k++) begin
      vectors++;
      if (bs[k] != exp_s[k] || bt[k] != exp_t[k]) begin
        miscompares++;
        $display("FAIL bp_seq b%0d: got src %0d tag %0d want src %0d tag %0d",
                 k, bs[k], bt[k], exp_s[k], exp_t[k]);
      end
    end
    if (nb == 5) begin
      vectors++;
      if (bc[3] != bc[2] + 1 || bc[4] != bc[3] + 1) begin
        miscompares++;
        $display("FAIL bp_back_to_back: got cycles %0d %0d %0d want consecutive", bc[2], bc[3], bc[4]);
      end
    end
    vectors++;
    if (blocked != (BYP ? 0 : 1)) begin
      miscompares++;
      $display("FAIL bp_blocked: got %0d want %0d", blocked, BYP ? 0 : 1);
    end
    idle();
  endtask

  task automatic test_squash();
    int first_src;
    do_reset();
    first_src = -1;
    for (int c = 0; c < 10 && first_src < 0; c++) begin
      idle();
      if (c == 0) begin set_fu(0, 1'b1, 5'd3, 32'h33); set_fu(2, 1'b1, 5'd7, 32'h77); end
      if (c == 1) begin squash = 1'b1; set_fu(1, 1'b1, 5'd9, 32'h99); end
      if (c == 5) for (int i = 0; i < 3; i++) set_fu(i, 1'b1, 5'(i + 1), 32'(i));
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL sq_model c%0d: got %h want %h", c, obs(), m_out());
      end
      if (c == 1) begin
        vectors++;
        if (bus.fu_ready !== 3'b000) begin
          miscompares++;
          $display("FAIL sq_ready: got %b want 000", bus.fu_ready);
        end
      end
      if (c >= 2 && c <= 5) begin
        vectors++;
        if (bus.cdb_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL sq_flushed c%0d: got cdb_valid %b want 0", c, bus.cdb_valid);
        end
      end
      if (c > 5 && bus.cdb_valid) first_src = int'(bus.cdb_src);
      tick();
    end
    vectors++;
    if (first_src != (BYP ? 1 : 0)) begin
      miscompares++;
      $display("FAIL sq_rr_held: got first src %0d want %0d", first_src, BYP ? 1 : 0);
    end
    idle();
  endtask

  task automatic test_wrap();
    int nb;
    int bs [4];
    int bt [4];
    int bc [4];
    do_reset();
    nb = 0;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) set_fu(1, 1'b1, 5'd4, 32'h44);
      if (c == 3) begin set_fu(0, 1'b1, 5'd6, 32'h66); set_fu(2, 1'b1, 5'd8, 32'h88); end
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL wrap_model c%0d: got %h want %h", c, obs(), m_out());
      end
      if (c >= 4 && bus.cdb_valid && nb < 4) begin
        bs[nb] = int'(bus.cdb_src); bt[nb] = int'(bus.cdb_tag); bc[nb] = c; nb++;
      end
      tick();
    end
    vectors++;
    if (nb != 2) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d want 2", nb);
    end else begin
      vectors++;
      if (bs[0] != 2 || bt[0] != 8 || bs[1] != 0 || bt[1] != 6 || bc[1] != bc[0] + 1) begin
        miscompares++;
        $display("FAIL wrap_order: got %0d/%0d then %0d/%0d want 2/8 then 0/6 back to back",
                 bs[0], bt[0], bs[1], bt[1]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int first_src;
    bit seen;
    seen = 1'b0;
    first_src = -1;
    for (int c = 0; c < 6 && !seen; c++) begin
      for (int i = 0; i < 3; i++) set_fu(i, 1'b1, 5'(i + 12), 32'(i) + 32'h500);
      @(negedge clock);
      if (bus.cdb_valid) seen = 1'b1;
      else tick();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rmid_timeout: got no broadcast want one within 6 cycles");
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== 43'd0) begin
      miscompares++;
      $display("FAIL rmid_async_clear: got %h want 0", obs());
    end
    model_reset();
    @(posedge clock); #1;
    idle();
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.fu_ready !== 3'b111) begin
      miscompares++;
      $display("FAIL rmid_release_ready: got %b want 111", bus.fu_ready);
    end
    tick();
    for (int c = 0; c < 5 && first_src < 0; c++) begin
      idle();
      if (c == 0) for (int i = 0; i < 3; i++) set_fu(i, 1'b1, 5'(i), 32'(i));
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL rmid_model c%0d: got %h want %h", c, obs(), m_out());
      end
      if (bus.cdb_valid) first_src = int'(bus.cdb_src);
      tick();
    end
    vectors++;
    if (first_src != 0) begin
      miscompares++;
      $display("FAIL rmid_rr_zero: got first src %0d want 0", first_src);
    end
    idle();
  endtask

  task automatic test_random();
    logic [2:0] held;
    logic [2:0] acc;
    do_reset();
    held = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!held[i] && $urandom_range(0, 1) == 1) begin
          held[i] = 1'b1;
          set_fu(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        end
        bus.fu_valid[i] = held[i];
      end
      squash = ($urandom_range(0, 15) == 0);
      @(negedge clock);
      vectors++;
      if (obs() !== m_out()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", c, obs(), m_out());
      end
      acc = bus.fu_ready & bus.fu_valid;
      tick();
      held = held & ~acc;
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    squash = 1'b0;
    bus.fu_valid = 3'b000;
    bus.fu_tag = 15'd0;
    bus.fu_value = 96'd0;
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_squash();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
